bcd_pulse_gen: RTL and testbench
================================

// Module: bcd_pulse_gen
// PURPOSE
//   Preset BCD pulse-train generator: the source side of the decade-counter chain.
//   Loads a DIGITS-digit BCD count and emits exactly that many clean pulses on PULSE_OUT.
//   Counts down in BCD and reports the remaining count, then flags completion.
//   Drives the Fin input of the decade counters, so a bench or self-test can generate a known count.
// PARAMETERS
//   DIGITS    4  number of BCD digits (count range 0..10^DIGITS-1)
//   HIGH_CYC  1  CLK cycles PULSE_OUT is high per pulse (>=1)
//   LOW_CYC   1  CLK cycles PULSE_OUT is low after each pulse (>=1)
// PORTS
//   CLK        in   1         system clock, all logic on posedge
//   CLR_N      in   1         synchronous active-low reset
//   ENABL      in   1         1 = run; 0 = freeze state, phase timer and outputs
//   START      in   1         load request, honoured only in IDLE
//   BCD_IN     in   4*DIGITS  preset count, digit 0 = bits[3:0] (units)
//   PULSE_OUT  out  1         generated pulse train
//   DOUT       out  4*DIGITS  remaining pulses, BCD
//   BUSY       out  1         1 from load until the last low phase ends
//   DONE       out  1         one-cycle strobe when the train completes
//   ERR        out  1         one-cycle strobe when START has an invalid BCD digit
// BEHAVIOUR
//   - Reset (CLR_N=0 at posedge): state=IDLE; PULSE_OUT, BUSY, DONE, ERR = 0;
//     DOUT = 0; phase timer = 0. Reset wins over every other input, including mid-train.
//   - All outputs are registered. Default for DONE/ERR is 0 on every cycle.
//   - FSM states: IDLE, HIGH, LOW.
//   - IDLE, START=1, ENABL=1:
//     any digit >9: ERR=1 next cycle, DOUT unchanged, stay IDLE.
//     BCD_IN==0: DONE=1 next cycle, DOUT=0, no pulse, stay IDLE.
//     else: DOUT<=BCD_IN, BUSY<=1, PULSE_OUT<=1, go HIGH. The first pulse starts the cycle after the START edge.
//   - HIGH: PULSE_OUT=1 for HIGH_CYC cycles.
//     On the last high cycle, DOUT decrements by 1 in BCD and PULSE_OUT<=0; go LOW.
//   - LOW: PULSE_OUT=0 for LOW_CYC cycles. On the last low cycle:
//     DOUT!=0: PULSE_OUT<=1, go HIGH.
//     DOUT==0: BUSY<=0, DONE<=1, go IDLE.
//   - BCD decrement: digit 0 minus 1. A digit at 0 becomes 9 and borrows from the next digit.
//     Digits never leave 0..9. Underflow cannot occur (DOUT>0 is checked before each pulse).
//   - Total BUSY time = N*(HIGH_CYC+LOW_CYC) cycles for preset N. DONE coincides with the first BUSY=0 cycle.
//   - ENABL=0: state, phase timer, DOUT and PULSE_OUT hold. No DONE or ERR is generated.
//     START is ignored while ENABL=0, even in IDLE.
//   - START while BUSY: ignored; BCD_IN is not sampled.
//   - START on the same cycle as the DONE strobe (state already IDLE): accepted normally.
// TESTING
//   1. HIGH=LOW=1, START with BCD_IN=16'h0003
//      -> PULSE_OUT 1,0,1,0,1,0; DOUT 3,2,2,1,1,0; DONE on cycle 7; BUSY high cycles 1-6.
//   2. BCD_IN=16'h0010 -> DOUT goes 0010 to 0009 after the first pulse (borrow); 10 pulses total.
//      BCD_IN=16'h1000 -> the first decrement gives 0999.
//   3. BCD_IN=16'h00A5 -> ERR=1 for 1 cycle, BUSY stays 0, no pulses.
//      BCD_IN=0 -> DONE=1 next cycle, no pulses.
//   4. HIGH=2, LOW=3, N=4, ENABL=0 for 5 cycles mid-HIGH
//      -> PULSE_OUT held high during the stall; 4 pulses; BUSY time = 4*5+5 = 25 cycles.
//   5. CLR_N=0 during the 2nd pulse of N=9 -> next cycle all outputs 0, IDLE.
//      A new START then runs cleanly. A START issued while BUSY is ignored.
//   6. N=9999 with HIGH=LOW=1 -> exactly 9999 rising edges counted on PULSE_OUT.
//      DOUT passes 9000->8999; DONE at cycle 19999.

Source files
------------

// File: rtl/bcd_pulse_gen_if.sv
// Control/status bundle of the preset BCD pulse-train generator.
// The master drives enabl/start/bcd_in; the generator (slave) returns the pulse train and status.
interface bcd_pulse_gen_if #(
   parameter int DIGITS = 4
);
   logic                  enabl;
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  pulse_out;
   logic [4*DIGITS-1:0]   dout;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output enabl, start, bcd_in,
      input  pulse_out, dout, busy, done, err
   );

   modport slave (
      input  enabl, start, bcd_in,
      output pulse_out, dout, busy, done, err
   );
endinterface

// File: rtl/bcd_pulse_gen.sv
// Preset BCD pulse-train generator: loads a BCD count and emits exactly that many pulses,
// counting the remaining pulses down in BCD and strobing done (or err on a bad preset).
module bcd_pulse_gen #(
   parameter int DIGITS   = 4,
   parameter int HIGH_CYC = 1,
   parameter int LOW_CYC  = 1
) (
   input  logic           clk,
   input  logic           clr_n,
   bcd_pulse_gen_if.slave bus
);
   localparam int W    = 4 * DIGITS;
   localparam int PMAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
   localparam int TW   = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam logic [TW-1:0] HIGH_LAST = TW'(HIGH_CYC - 1);
   localparam logic [TW-1:0] LOW_LAST  = TW'(LOW_CYC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic [W-1:0]  dout_r, dout_nxt;
   logic          pulse_r, pulse_nxt;
   logic          busy_r, busy_nxt;
   logic          done_r, done_nxt;
   logic          err_r, err_nxt;

   logic          high_last, low_last, load_req, preset_ok, preset_zero;

   function automatic logic bcd_valid(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   // Ripple-borrow decrement: a zero digit wraps to 9 and passes the borrow upward.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign high_last   = (tmr == HIGH_LAST);
   assign low_last    = (tmr == LOW_LAST);
   assign load_req    = bus.enabl && bus.start;
   assign preset_ok   = bcd_valid(bus.bcd_in);
   assign preset_zero = (bus.bcd_in == '0);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state   <= IDLE;
         tmr     <= '0;
         dout_r  <= '0;
         pulse_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_nxt;
         tmr     <= tmr_nxt;
         dout_r  <= dout_nxt;
         pulse_r <= pulse_nxt;
         busy_r  <= busy_nxt;
         done_r  <= done_nxt;
         err_r   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (bus.enabl) begin
         case (state)
            IDLE:    if (load_req && preset_ok && !preset_zero) state_nxt = HIGH;
            HIGH:    if (high_last) state_nxt = LOW;
            LOW:     if (low_last) state_nxt = (dout_r == '0) ? IDLE : HIGH;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // With enabl low everything holds and the strobes stay quiet.
   always_comb begin
      tmr_nxt   = tmr;
      dout_nxt  = dout_r;
      pulse_nxt = pulse_r;
      busy_nxt  = busy_r;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (bus.enabl) begin
         case (state)
            IDLE: begin
               if (load_req) begin
                  if (!preset_ok) begin
                     err_nxt = 1'b1;
                  end else if (preset_zero) begin
                     done_nxt = 1'b1;
                     dout_nxt = '0;
                  end else begin
                     dout_nxt  = bus.bcd_in;
                     busy_nxt  = 1'b1;
                     pulse_nxt = 1'b1;
                     tmr_nxt   = '0;
                  end
               end
            end
            HIGH: begin
               if (high_last) begin
                  dout_nxt  = bcd_dec(dout_r);
                  pulse_nxt = 1'b0;
                  tmr_nxt   = '0;
               end else begin
                  tmr_nxt = tmr + 1'b1;
               end
            end
            LOW: begin
               if (low_last) begin
                  tmr_nxt = '0;
                  if (dout_r != '0) begin
                     pulse_nxt = 1'b1;
                  end else begin
                     busy_nxt = 1'b0;
                     done_nxt = 1'b1;
                  end
               end else begin
                  tmr_nxt = tmr + 1'b1;
               end
            end
            default: begin
               tmr_nxt = '0;
            end
         endcase
      end
   end

   assign bus.pulse_out = pulse_r;
   assign bus.dout      = dout_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
endmodule

// File: tb/tb_bcd_pulse_gen.sv
// Bench for bcd_pulse_gen: one instance with 1/1 phases for the vector table and corner
// sequences, a second with 2/3 phases for the enable-stall case.
module tb_bcd_pulse_gen;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bcd_pulse_gen_if #(.DIGITS(4)) b1 ();
   bcd_pulse_gen_if #(.DIGITS(4)) b2 ();

   bcd_pulse_gen #(.DIGITS(4), .HIGH_CYC(1), .LOW_CYC(1)) dut1 (
      .clk(clk), .clr_n(clr_n), .bus(b1)
   );
   bcd_pulse_gen #(.DIGITS(4), .HIGH_CYC(2), .LOW_CYC(3)) dut2 (
      .clk(clk), .clr_n(clr_n), .bus(b2)
   );

   typedef struct {
      logic [15:0] bcd;
      logic [15:0] dout1;
      bit          err;
      bit          inj;
      bit          done;
      int          pulses;
      int          busy;
   } vec_t;

   vec_t sb_q[$];
   vec_t tbl[8];
   logic [18:0] t1_exp[7];

   function automatic int bcd2int(input logic [15:0] v);
      int r;
      r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [15:0] v);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic vec_t mk(input logic [15:0] bcd, input logic [15:0] d1,
                               input bit err, input bit inj);
      vec_t v;
      v.bcd    = bcd;
      v.dout1  = d1;
      v.err    = err;
      v.inj    = inj;
      v.done   = !err;
      v.pulses = err ? 0 : bcd2int(bcd);
      v.busy   = v.pulses * 2;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Watches one train on b1 from the first cycle after the START edge up to the done/err strobe.
   task automatic mon1(input bit inj);
      vec_t        e;
      int          pulses, busy_cyc, n, bad_seq;
      bit          prev, fell, gd, ge;
      logic [15:0] d1, prev_d;
      pulses = 0; busy_cyc = 0; n = 0; bad_seq = 0;
      prev = 1'b0; fell = 1'b0; gd = 1'b0; ge = 1'b0;
      d1 = '0;
      prev_d = b1.dout;
      while (!gd && !ge && n < 25000) begin
         if (b1.pulse_out && !prev) pulses++;
         if (!b1.pulse_out && prev && !fell) begin
            fell = 1'b1;
            d1   = b1.dout;
         end
         prev = b1.pulse_out;
         if (b1.dout != prev_d) begin
            if (!bcd_ok(b1.dout) || bcd2int(b1.dout) != bcd2int(prev_d) - 1) bad_seq++;
            prev_d = b1.dout;
         end
         if (b1.busy) busy_cyc++;
         if (b1.done) gd = 1'b1;
         if (b1.err)  ge = 1'b1;
         if (!gd && !ge) begin
            if (inj && n == 1) begin
               b1.start  = 1'b1;
               b1.bcd_in = 16'h0009;
            end else begin
               b1.start = 1'b0;
            end
            @(negedge clk);
            n++;
         end
      end
      e = sb_q.pop_front();
      chk("timeout", 32'(n >= 25000), 32'd0);
      chk($sformatf("err_%04h", e.bcd), 32'(ge), 32'(e.err));
      chk($sformatf("done_%04h", e.bcd), 32'(gd), 32'(e.done));
      chk($sformatf("pulses_%04h", e.bcd), 32'(pulses), 32'(e.pulses));
      chk($sformatf("busy_cycles_%04h", e.bcd), 32'(busy_cyc), 32'(e.busy));
      chk($sformatf("dout_seq_%04h", e.bcd), 32'(bad_seq), 32'd0);
      chk($sformatf("dout_end_%04h", e.bcd), 32'(b1.dout), 32'd0);
      if (e.pulses > 0) chk($sformatf("dout_first_dec_%04h", e.bcd), 32'(d1), 32'(e.dout1));
   endtask

   task automatic drive1(input logic [15:0] bcd);
      b1.start  = 1'b1;
      b1.bcd_in = bcd;
      @(negedge clk);
      b1.start  = 1'b0;
   endtask

   task automatic run1(input vec_t v);
      sb_q.push_back(v);
      @(negedge clk);
      drive1(v.bcd);
      mon1(v.inj);
      @(negedge clk);
      chk("strobes_clear", 32'({b1.done, b1.err, b1.busy, b1.pulse_out}), 32'd0);
   endtask

   initial begin
      int          pulses, busy_cyc, n, stall_bad;
      bit          prev, gd;

      b1.enabl = 1'b1; b1.start = 1'b0; b1.bcd_in = '0;
      b2.enabl = 1'b1; b2.start = 1'b0; b2.bcd_in = '0;

      t1_exp[0] = {1'b1, 1'b1, 1'b0, 16'h0003};
      t1_exp[1] = {1'b0, 1'b1, 1'b0, 16'h0002};
      t1_exp[2] = {1'b1, 1'b1, 1'b0, 16'h0002};
      t1_exp[3] = {1'b0, 1'b1, 1'b0, 16'h0001};
      t1_exp[4] = {1'b1, 1'b1, 1'b0, 16'h0001};
      t1_exp[5] = {1'b0, 1'b1, 1'b0, 16'h0000};
      t1_exp[6] = {1'b0, 1'b0, 1'b1, 16'h0000};

      tbl[0] = mk(16'h0003, 16'h0002, 1'b0, 1'b0);
      tbl[1] = mk(16'h0010, 16'h0009, 1'b0, 1'b0);
      tbl[2] = mk(16'h1000, 16'h0999, 1'b0, 1'b0);
      tbl[3] = mk(16'h00A5, 16'h0000, 1'b1, 1'b0);
      tbl[4] = mk(16'h0000, 16'h0000, 1'b0, 1'b0);
      tbl[5] = mk(16'h0003, 16'h0002, 1'b0, 1'b1);
      tbl[6] = mk(16'h0001, 16'h0000, 1'b0, 1'b0);
      tbl[7] = mk(16'h9999, 16'h9998, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("reset_dut1", 32'({b1.pulse_out, b1.busy, b1.done, b1.err, b1.dout}), 32'd0);
      chk("reset_dut2", 32'({b2.pulse_out, b2.busy, b2.done, b2.err, b2.dout}), 32'd0);
      clr_n = 1'b1;

      // Cycle-exact train for a preset of 3
      @(negedge clk);
      drive1(16'h0003);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("n3_cycle%0d", k + 1),
             32'({b1.pulse_out, b1.busy, b1.done, b1.dout}), 32'(t1_exp[k]));
         @(negedge clk);
      end
      chk("n3_after_done", 32'({b1.pulse_out, b1.busy, b1.done}), 32'd0);

      for (int i = 0; i < 8; i++) begin
         if (i != 7) run1(tbl[i]);
      end

      // START landing on the DONE strobe cycle is accepted
      @(negedge clk);
      sb_q.push_back(mk(16'h0001, 16'h0000, 1'b0, 1'b0));
      drive1(16'h0001);
      mon1(1'b0);
      chk("b2b_done_seen", 32'(b1.done), 32'd1);
      sb_q.push_back(mk(16'h0002, 16'h0001, 1'b0, 1'b0));
      drive1(16'h0002);
      mon1(1'b0);

      // START with enabl low is ignored even in IDLE
      @(negedge clk);
      b1.enabl = 1'b0;
      drive1(16'h0005);
      b1.enabl = 1'b1;
      chk("enabl_low_start", 32'({b1.busy, b1.pulse_out, b1.done, b1.dout}), 32'd0);
      @(negedge clk);
      chk("enabl_low_start_late", 32'({b1.busy, b1.pulse_out}), 32'd0);

      // Reset during the second pulse of a 9-pulse train
      drive1(16'h0009);
      @(negedge clk);
      @(negedge clk);
      chk("second_pulse_high", 32'({b1.pulse_out, b1.dout}), 32'({1'b1, 16'h0008}));
      clr_n = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      chk("reset_mid_train", 32'({b1.pulse_out, b1.busy, b1.done, b1.err, b1.dout}), 32'd0);
      run1(mk(16'h0002, 16'h0001, 1'b0, 1'b0));

      // HIGH=2/LOW=3, four pulses, enabl low for five cycles in the first high phase
      @(negedge clk);
      b2.start = 1'b1; b2.bcd_in = 16'h0004;
      @(negedge clk);
      b2.start = 1'b0;
      pulses = 0; busy_cyc = 0; n = 0; stall_bad = 0; prev = 1'b0; gd = 1'b0;
      while (!gd && n < 200) begin
         if (b2.pulse_out && !prev) pulses++;
         prev = b2.pulse_out;
         if (b2.busy) busy_cyc++;
         if (b2.done) gd = 1'b1;
         if (n >= 1 && n <= 5 && !b2.pulse_out) stall_bad++;
         if (!gd) begin
            b2.enabl = !(n <= 4);
            @(negedge clk);
            n++;
         end
      end
      b2.enabl = 1'b1;
      chk("stall_pulse_held", 32'(stall_bad), 32'd0);
      chk("stall_done", 32'(gd), 32'd1);
      chk("stall_pulses", 32'(pulses), 32'd4);
      chk("stall_busy_cycles", 32'(busy_cyc), 32'd25);
      chk("stall_dout_end", 32'(b2.dout), 32'd0);

      run1(tbl[7]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
